// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle CPU front end.
// Contents:
//   - opcode constants decoded by the fetch unit and control unit
//   - fault_code encodings reported by pc_fetch_unit
//   - fetch FSM state encoding
//   - branch_offset(): sign-extended, word-scaled branch displacement
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b010101;
    localparam logic [5:0] OP_JR    = 6'b010110;
    localparam logic [5:0] OP_JAL   = 6'b010111;
    localparam logic [5:0] OP_BEQ   = 6'b001010;
    localparam logic [5:0] OP_BNEQ  = 6'b001011;
    localparam logic [5:0] OP_BGEZ  = 6'b001100;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        StRst,
        StFetch,
        StExec,
        StHalt
    } fetch_state_e;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection.
// Ports:
//   pc_plus4  in  32  address of the sequentially following instruction
//   instr     in  32  instruction currently in EXEC
//   branch    in  1   Branch from control unit
//   jump      in  1   jump from control unit
//   alu_zero  in  1   ALU zero flag
//   jr_target in  32  rs value for JR
//   next_pc   out 32  selected next PC (alignment is checked by the caller)
module next_pc_logic
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        jump,
    input  logic        alu_zero,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc_plus4;
        if (jump && (instr[31:26] == OP_JR)) begin
            next_pc = jr_target;
        end else if (jump) begin
            // Any opcode with jump set other than JR takes the pseudo-direct form.
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && alu_zero) begin
            next_pc = pc_plus4 + branch_offset(instr[15:0]);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, instruction fetch over a req/ack handshake, and next-PC update.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   stall                  hold the current instruction in EXEC
//   imem_req/addr          fetch request and address (= pc)
//   imem_ack/rdata         memory response, honoured only in FETCH
//   instr, opcode          latched instruction and its instr[31:26]
//   instr_valid            high while the datapath executes instr
//   pc, pc_plus4           address of instr and its sequential successor
//   branch, jump, alu_zero control inputs, sampled in EXEC when stall=0
//   jr_target              rs value for JR
//   fault, fault_code      sticky fault flag and cause
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic        jump,
    input  logic        alu_zero,
    input  logic [31:0] jr_target,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         fault_q, fault_d;
    logic [1:0]   fault_code_q, fault_code_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [31:0]  next_pc;

    next_pc_logic u_next_pc_logic (
        .pc_plus4  (pc_plus4),
        .instr     (instr_q),
        .branch    (branch),
        .jump      (jump),
        .alu_zero  (alu_zero),
        .jr_target (jr_target),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRst;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            StRst: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    cnt_d   = '0;
                    state_d = StExec;
                end else if (cnt_q == TO_LAST) begin
                    fault_d      = 1'b1;
                    fault_code_d = FAULT_TIMEOUT;
                    cnt_d        = '0;
                    state_d      = StHalt;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StExec: begin
                if (!stall) begin
                    if (next_pc[1:0] != 2'b00) begin
                        // PC is left pointing at the offending instruction.
                        fault_d      = 1'b1;
                        fault_code_d = FAULT_MISALIGN;
                        state_d      = StHalt;
                    end else begin
                        pc_d    = next_pc;
                        state_d = StFetch;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StRst;
            end
        endcase
    end

    // Decoded straight from state so reset drops imem_req asynchronously.
    assign imem_req    = (state_q == StFetch);
    assign instr_valid = (state_q == StExec);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, branches, jumps, stall,
// PC wrap, misaligned-target fault, mid-fetch reset and fetch timeout.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch;
    logic        jump;
    logic        alu_zero;
    logic [31:0] jr_target;
    logic        fault;
    logic [1:0]  fault_code;

    logic ack_en;
    logic ack_force;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Zero-wait memory when enabled; ack_force drives ack regardless of req.
    assign imem_ack = ack_force | (ack_en & imem_req);

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0100),
        .TIMEOUT  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .branch      (branch),
        .jump        (jump),
        .alu_zero    (alu_zero),
        .jr_target   (jr_target),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctl;
        stall     = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        alu_zero  = 1'b0;
        jr_target = 32'h0;
    endtask

    // Called at a negedge in FETCH; returns at the negedge of the EXEC cycle.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
        chk("fetch_req", {31'b0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, addr);
        chk("fetch_valid", {31'b0, instr_valid}, 32'd0);
        imem_rdata = word;
        step();
        chk("exec_valid", {31'b0, instr_valid}, 32'd1);
        chk("exec_instr", instr, word);
        chk("exec_opcode", {26'b0, opcode}, {26'b0, word[31:26]});
        chk("exec_pc", pc, addr);
        chk("exec_pc4", pc_plus4, addr + 32'd4);
        chk("exec_req", {31'b0, imem_req}, 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        ack_en     = 1'b1;
        ack_force  = 1'b0;
        imem_rdata = 32'h0;
        clear_ctl();

        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_code", {30'b0, fault_code}, 32'd0);
        chk("rst_pc", pc, 32'h100);
        chk("rst_instr", instr, 32'h0);

        rst_n = 1'b1;
        chk("rst_cycle_req", {31'b0, imem_req}, 32'd0);
        step();

        // Sequential fetch 100, 104, 108 with zero-wait memory.
        fetch(32'h100, 32'h0000_0000);
        step();
        fetch(32'h104, 32'h0000_0000);
        step();
        // J 0x200
        fetch(32'h108, 32'h5400_0080);
        jump = 1'b1;
        step();
        clear_ctl();

        // BEQ offset -2 words, taken: 0x204 - 8 = 0x1FC
        fetch(32'h200, 32'h2800_FFFE);
        branch = 1'b1;
        alu_zero = 1'b1;
        step();
        clear_ctl();
        fetch(32'h1FC, 32'h5400_0080);
        jump = 1'b1;
        step();
        clear_ctl();
        // Same branch not taken
        fetch(32'h200, 32'h2800_FFFE);
        branch = 1'b1;
        step();
        clear_ctl();

        // JR to 0x3000_0010, then J keeps pc_plus4[31:28]
        fetch(32'h204, 32'h5800_0000);
        jump = 1'b1;
        jr_target = 32'h3000_0010;
        step();
        clear_ctl();
        fetch(32'h3000_0010, 32'h5400_0040);
        jump = 1'b1;
        step();
        clear_ctl();
        fetch(32'h3000_0100, 32'h5800_0000);
        jump = 1'b1;
        jr_target = 32'h44;
        step();
        clear_ctl();

        // Stall over three EXEC cycles with jump asserted and a stray ack.
        fetch(32'h44, 32'h5400_0020);
        stall = 1'b1;
        jump = 1'b1;
        ack_force = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (2) begin
            step();
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_pc", pc, 32'h44);
            chk("stall_instr", instr, 32'h5400_0020);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
        end
        stall = 1'b0;
        ack_force = 1'b0;
        step();
        clear_ctl();

        // PC wrap through 0xFFFF_FFFC
        fetch(32'h80, 32'h5800_0000);
        jump = 1'b1;
        jr_target = 32'hFFFF_FFFC;
        step();
        clear_ctl();
        fetch(32'hFFFF_FFFC, 32'h0000_0000);
        step();
        chk("wrap_fault", {31'b0, fault}, 32'd0);

        // Misaligned JR target halts with PC on the JR.
        fetch(32'h0, 32'h5800_0000);
        jump = 1'b1;
        jr_target = 32'h45;
        step();
        clear_ctl();
        chk("mis_fault", {31'b0, fault}, 32'd1);
        chk("mis_code", {30'b0, fault_code}, 32'd1);
        chk("mis_pc", pc, 32'h0);
        chk("mis_req", {31'b0, imem_req}, 32'd0);
        chk("mis_valid", {31'b0, instr_valid}, 32'd0);
        repeat (3) step();
        chk("halt_fault", {31'b0, fault}, 32'd1);
        chk("halt_code", {30'b0, fault_code}, 32'd1);
        chk("halt_pc", pc, 32'h0);
        chk("halt_req", {31'b0, imem_req}, 32'd0);
        chk("halt_opcode", {26'b0, opcode}, 32'h16);

        // Reset pulse clears the fault; no acks from here on.
        rst_n = 1'b0;
        ack_en = 1'b0;
        #1;
        chk("rst2_fault", {31'b0, fault}, 32'd0);
        chk("rst2_pc", pc, 32'h100);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("to0_req", {31'b0, imem_req}, 32'd1);

        // Reset mid-FETCH drops imem_req immediately.
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Timeout after four unacknowledged FETCH cycles.
        chk("to1_req", {31'b0, imem_req}, 32'd1);
        step();
        step();
        step();
        chk("to4_req", {31'b0, imem_req}, 32'd1);
        chk("to4_fault", {31'b0, fault}, 32'd0);
        step();
        chk("to_fault", {31'b0, fault}, 32'd1);
        chk("to_code", {30'b0, fault_code}, 32'd2);
        chk("to_req", {31'b0, imem_req}, 32'd0);
        step();
        chk("to_hold_req", {31'b0, imem_req}, 32'd0);
        chk("to_hold_code", {30'b0, fault_code}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
